// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the LCD command sequencer.
// Holds the command code map, the sequencer FSM encoding, the command ROM
// geometry, the watchdog limit and a legality helper.
package lcd_pkg;

  // Command ROM geometry
  localparam int ROM_DEPTH = 32;
  localparam int ROM_AW    = 5;
  localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(ROM_DEPTH - 1);

  // Command codes: 0 = WRITE, 1..11 = image operations, 12..15 = illegal
  localparam int CMD_W = 4;
  localparam logic [CMD_W-1:0] CMD_WRITE       = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ILLEGAL_MIN = 4'd12;

  // Issued-command counter saturates at all-ones
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Watchdog
  localparam int WDT_W = 8;
  localparam logic [WDT_W-1:0] WDT_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_ACK,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] c);
    return c < CMD_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/lcd_seq_wdt.sv
// lcd_seq_wdt -- watchdog cycle counter for the LCD command sequencer.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   clr     : restart the count from zero (takes priority over en)
//   en      : count this cycle
//   expired : count has reached WDT_LIMIT while enabled
module lcd_seq_wdt
  import lcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDT_W-1:0] count_reg;
  logic [WDT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != WDT_LIMIT)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = en && (count_reg == WDT_LIMIT);

endmodule

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq -- fetches commands from a 32-entry command ROM and hands them
// one at a time to an LCD controller, skipping illegal codes, forcing a
// terminating WRITE at the end of the ROM, and aborting on a watchdog timeout.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   start               : one-cycle pulse, launches a program from address 0
//   CROM_rd, CROM_A     : ROM read strobe / address (data one cycle later)
//   CROM_Q              : ROM read data
//   cmd, cmd_valid      : command and strobe to the LCD controller
//   busy, done          : controller busy / write-back complete
//   seq_done, err       : program finished / watchdog timeout (held)
//   cmd_cnt             : commands issued in the current program (saturating)
module lcd_cmd_seq
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CMD_W-1:0]  CROM_Q,
  output logic              CROM_rd,
  output logic [ROM_AW-1:0] CROM_A,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic              seq_done,
  output logic              err,
  output logic [CNT_W-1:0]  cmd_cnt
);

  state_t              state_reg, state_next;
  logic [ROM_AW-1:0]   addr_reg, addr_next;
  logic [CMD_W-1:0]    cmd_reg, cmd_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                seq_done_reg, seq_done_next;
  logic                err_reg, err_next;

  logic wdt_clr;
  logic wdt_en;
  logic wdt_expired;

  // The watchdog only runs in the states that wait on the controller and
  // restarts whenever the FSM moves.
  assign wdt_en  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_BUSY) ||
                   (state_reg == ST_WAIT_DONE);
  assign wdt_clr = (state_next != state_reg);

  lcd_seq_wdt u_wdt (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      cmd_reg      <= '0;
      cnt_reg      <= '0;
      seq_done_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cmd_reg      <= cmd_next;
      cnt_reg      <= cnt_next;
      seq_done_reg <= seq_done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cmd_next      = cmd_reg;
    cnt_next      = cnt_reg;
    seq_done_next = seq_done_reg;
    err_next      = err_reg;
    CROM_rd       = 1'b0;
    cmd_valid     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next     = '0;
          cnt_next      = '0;
          seq_done_next = 1'b0;
          err_next      = 1'b0;
          state_next    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        CROM_rd    = 1'b1;
        state_next = ST_LATCH;
      end

      ST_LATCH: begin
        if (cmd_is_legal(CROM_Q)) begin
          cmd_next   = CROM_Q;
          state_next = ST_ISSUE;
        end else if (addr_reg == ADDR_LAST) begin
          // Nothing left to read: terminate the program with a WRITE so
          // the sequencer still reaches FINISH.
          cmd_next   = CMD_WRITE;
          state_next = ST_ISSUE;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_ISSUE: begin
        if (wdt_expired) begin
          err_next      = 1'b1;
          seq_done_next = 1'b0;
          state_next    = ST_IDLE;
        end else if (!busy) begin
          cmd_valid  = 1'b1;
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
          end
          state_next = ST_ACK;
        end
      end

      // The controller may raise busy in response to the strobe; give it
      // a cycle before busy is looked at again.
      ST_ACK: begin
        state_next = (cmd_reg == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (wdt_expired) begin
          err_next      = 1'b1;
          seq_done_next = 1'b0;
          state_next    = ST_IDLE;
        end else if (!busy) begin
          if (addr_reg == ADDR_LAST) begin
            // End of ROM: force the closing WRITE without a read; the
            // address stays at the last entry.
            cmd_next   = CMD_WRITE;
            state_next = ST_ISSUE;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end

      ST_WAIT_DONE: begin
        if (wdt_expired) begin
          err_next      = 1'b1;
          seq_done_next = 1'b0;
          state_next    = ST_IDLE;
        end else if (done) begin
          state_next = ST_FINISH;
        end
      end

      ST_FINISH: begin
        seq_done_next = 1'b1;
        state_next    = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign CROM_A   = addr_reg;
  assign cmd      = cmd_reg;
  assign cmd_cnt  = cnt_reg;
  assign seq_done = seq_done_reg;
  assign err      = err_reg;

endmodule
